// File: rtl/mod_sub64_pipe.sv
// Two-stage pipelined modular subtractor: (a - b) mod MOD_P with valid/ready flow control,
// a pass-through sideband tag, a borrow indication and a sticky out-of-range flag.
module mod_sub64_pipe #(
  parameter int unsigned           DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] MOD_P      = 64'hFFFFFFFF00000001,
  parameter int unsigned           TAG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic [TAG_WIDTH-1:0]  tag_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] diff_out,
  output logic [TAG_WIDTH-1:0]  tag_out,
  output logic                  borrow_out,
  output logic                  range_err
);

  logic ce;

  // Stage 1 state: raw 65-bit difference (top bit is the borrow) and tag.
  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH:0]   d1_q, d1_d;
  logic [TAG_WIDTH-1:0]  tag1_q, tag1_d;

  // Stage 2 / output state.
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] diff_q, diff_d;
  logic [TAG_WIDTH-1:0]  tag_out_q, tag_out_d;
  logic                  borrow_q, borrow_d;
  logic                  range_err_q, range_err_d;

  logic [DATA_WIDTH:0]   sub_full;
  logic                  bor1;
  logic                  in_oor;

  // Both stages advance together; a held output freezes the whole pipe.
  assign ce       = ~out_valid_q | out_ready;
  assign in_ready = ce;

  always_comb begin
    sub_full = {1'b0, a_in} + ~{1'b0, b_in} + {{DATA_WIDTH{1'b0}}, 1'b1};
    bor1     = d1_q[DATA_WIDTH];
    in_oor   = (a_in >= MOD_P) | (b_in >= MOD_P);
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    d1_d        = d1_q;
    tag1_d      = tag1_q;
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    tag_out_d   = tag_out_q;
    borrow_d    = borrow_q;
    range_err_d = range_err_q;

    if (ce) begin
      s1_valid_d  = in_valid;
      d1_d        = sub_full;
      tag1_d      = tag_in;
      out_valid_d = s1_valid_q;
      // Add-back wraps modulo 2^DATA_WIDTH; the carry-out is intentionally dropped.
      diff_d      = bor1 ? (d1_q[DATA_WIDTH-1:0] + MOD_P) : d1_q[DATA_WIDTH-1:0];
      tag_out_d   = tag1_q;
      borrow_d    = bor1;
    end

    if (in_valid && ce && in_oor) begin
      range_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      d1_q        <= '0;
      tag1_q      <= '0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      tag_out_q   <= '0;
      borrow_q    <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      d1_q        <= d1_d;
      tag1_q      <= tag1_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      tag_out_q   <= tag_out_d;
      borrow_q    <= borrow_d;
      range_err_q <= range_err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign diff_out   = diff_q;
  assign tag_out    = tag_out_q;
  assign borrow_out = borrow_q;
  assign range_err  = range_err_q;

endmodule

// File: tb/tb_mod_sub64_pipe.sv
// Self-checking bench for mod_sub64_pipe: directed cases plus randomized traffic scored
// against a queue-based arithmetic model of (a - b) mod P.
module tb_mod_sub64_pipe;

  localparam logic [63:0] P = 64'hFFFFFFFF00000001;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic [7:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff_out;
  logic [7:0]  tag_out;
  logic        borrow_out;
  logic        range_err;

  mod_sub64_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff_out  (diff_out),
    .tag_out   (tag_out),
    .borrow_out(borrow_out),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic        b;
    logic [7:0]  t;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_fired  = 0;
  logic model_range = 1'b0;

  task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_sub(input logic [63:0] a, input logic [63:0] b);
    if (a >= b) return a - b;
    return a - b + P;
  endfunction

  // One clock: score the handshakes seen before the edge, then check state after it.
  task automatic cycle();
    logic        acc, fire, stalled, rst_s;
    logic [63:0] s_diff;
    logic [7:0]  s_tag;
    logic        s_bor;
    exp_t        e;
    #1;
    rst_s   = rst;
    acc     = in_valid && in_ready;
    fire    = out_valid && out_ready;
    stalled = out_valid && !out_ready && !rst;
    s_diff  = diff_out;
    s_tag   = tag_out;
    s_bor   = borrow_out;
    check_eq("in_ready_rule", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
    if (!rst_s) begin
      if (fire) begin
        n_fired++;
        if (sb.size() == 0) begin
          check_eq("spurious_out", {63'd0, out_valid}, 64'd0);
        end else begin
          e = sb.pop_front();
          check_eq("sb_diff", diff_out, e.d);
          check_eq("sb_borrow", {63'd0, borrow_out}, {63'd0, e.b});
          check_eq("sb_tag", {56'd0, tag_out}, {56'd0, e.t});
        end
      end
      if (acc) begin
        e.d = ref_sub(a_in, b_in);
        e.b = (a_in < b_in);
        e.t = tag_in;
        sb.push_back(e);
        if (a_in >= P || b_in >= P) model_range = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (rst_s) begin
      sb.delete();
      model_range = 1'b0;
    end
    check_eq("range_err", {63'd0, range_err}, {63'd0, model_range});
    if (stalled) begin
      check_eq("stall_valid", {63'd0, out_valid}, 64'd1);
      check_eq("stall_diff", diff_out, s_diff);
      check_eq("stall_tag", {56'd0, tag_out}, {56'd0, s_tag});
      check_eq("stall_borrow", {63'd0, borrow_out}, {63'd0, s_bor});
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic [7:0] t);
    in_valid = v;
    a_in     = a;
    b_in     = b;
    tag_in   = t;
  endtask

  function automatic logic [63:0] rand_op();
    logic [63:0] r;
    case ($urandom_range(0, 7))
      0:       r = 64'd0;
      1:       r = P - 64'd1;
      2:       r = 64'($urandom_range(0, 15));
      default: begin
        r = {$urandom, $urandom};
        r = r % P;
      end
    endcase
    return r;
  endfunction

  logic [63:0] hold_diff;
  int          fired0;

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 64'd0, 64'd0, 8'd0);
    cycle();
    cycle();
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_diff", diff_out, 64'd0);
    check_eq("rst_tag", {56'd0, tag_out}, 64'd0);
    check_eq("rst_borrow", {63'd0, borrow_out}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b0;

    // Test 1: basic subtraction with exact two-edge latency.
    drive(1'b1, 64'd5, 64'd3, 8'h11);
    cycle();
    drive(1'b0, 64'd0, 64'd0, 8'd0);
    check_eq("t1_lat_early", {63'd0, out_valid}, 64'd0);
    cycle();
    check_eq("t1_valid", {63'd0, out_valid}, 64'd1);
    check_eq("t1_diff", diff_out, 64'd2);
    check_eq("t1_borrow", {63'd0, borrow_out}, 64'd0);
    check_eq("t1_tag", {56'd0, tag_out}, 64'h11);

    // Test 2: borrow cases.
    drive(1'b1, 64'd3, 64'd5, 8'h22);
    cycle();
    drive(1'b0, 64'd0, 64'd0, 8'd0);
    cycle();
    check_eq("t2a_diff", diff_out, 64'hFFFFFFFEFFFFFFFF);
    check_eq("t2a_borrow", {63'd0, borrow_out}, 64'd1);
    drive(1'b1, 64'd0, 64'hFFFFFFFF00000000, 8'h23);
    cycle();
    drive(1'b0, 64'd0, 64'd0, 8'd0);
    cycle();
    check_eq("t2b_diff", diff_out, 64'd1);
    check_eq("t2b_borrow", {63'd0, borrow_out}, 64'd1);
    cycle();

    // Test 3: 8 back-to-back pairs at full throughput.
    fired0 = n_fired;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 64'(i + 10), 64'(i), 8'(i));
      cycle();
      check_eq("t3_in_ready", {63'd0, in_ready}, 64'd1);
    end
    drive(1'b0, 64'd0, 64'd0, 8'd0);
    for (int i = 0; i < 4; i++) cycle();
    check_eq("t3_count", 64'(n_fired - fired0), 64'd8);

    // Test 4: backpressure with two results queued.
    drive(1'b1, 64'd100, 64'd1, 8'hA0);
    cycle();
    drive(1'b1, 64'd1, 64'd100, 8'hA1);
    cycle();
    drive(1'b0, 64'd0, 64'd0, 8'd0);
    out_ready = 1'b0;
    hold_diff = diff_out;
    check_eq("t4_first", hold_diff, 64'd99);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_eq("t4_in_ready", {63'd0, in_ready}, 64'd0);
      check_eq("t4_hold_diff", diff_out, 64'd99);
      check_eq("t4_hold_tag", {56'd0, tag_out}, 64'hA0);
    end
    out_ready = 1'b1;
    cycle();
    check_eq("t4_second_valid", {63'd0, out_valid}, 64'd1);
    check_eq("t4_second_diff", diff_out, P - 64'd99);
    check_eq("t4_second_tag", {56'd0, tag_out}, 64'hA1);
    cycle();
    check_eq("t4_no_dup", {63'd0, out_valid}, 64'd0);

    // Test 5: out-of-range operand sets sticky flag.
    drive(1'b1, P, 64'd0, 8'h55);
    cycle();
    drive(1'b0, 64'd0, 64'd0, 8'd0);
    check_eq("t5_range_set", {63'd0, range_err}, 64'd1);

    // Randomized traffic with random backpressure and bubbles.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, rand_op(), rand_op(), 8'($urandom));
      if ($urandom_range(0, 9) == 0) b_in = a_in;
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    check_eq("t5_range_sticky", {63'd0, range_err}, 64'd1);

    // Test 6: reset with two results in flight.
    out_ready = 1'b1;
    drive(1'b1, 64'd1, 64'd2, 8'h61);
    cycle();
    drive(1'b1, 64'd3, 64'd4, 8'h62);
    cycle();
    drive(1'b0, 64'd0, 64'd0, 8'd0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_eq("t6_valid_clr", {63'd0, out_valid}, 64'd0);
    check_eq("t6_range_clr", {63'd0, range_err}, 64'd0);
    drive(1'b1, 64'd7, 64'd7, 8'h77);
    cycle();
    drive(1'b0, 64'd0, 64'd0, 8'd0);
    check_eq("t6_no_stale", {63'd0, out_valid}, 64'd0);
    cycle();
    check_eq("t6_valid", {63'd0, out_valid}, 64'd1);
    check_eq("t6_diff", diff_out, 64'd0);
    check_eq("t6_borrow", {63'd0, borrow_out}, 64'd0);
    check_eq("t6_tag", {56'd0, tag_out}, 64'h77);

    // Drain with a bounded wait.
    for (int i = 0; i < 10 && sb.size() != 0; i++) cycle();
    cycle();
    check_eq("drain_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
